// File: rtl/udp_tx_sched_if.sv
// Bundle between the packet sources, the round-robin scheduler and the UDP transmit engine.
// The master side is the scheduler; the slave side is everything around it.
interface udp_tx_sched_if #(
  parameter int N = 4
);
  logic [N-1:0]      req;
  logic [11*N-1:0]   req_len;
  logic [16*N-1:0]   req_port;
  logic              done;
  logic              start;
  logic [10:0]       len;
  logic [15:0]       dst_port;
  logic [N-1:0]      grant;
  logic [N-1:0]      ack;
  logic              err;

  modport master (
    input  req, req_len, req_port, done,
    output start, len, dst_port, grant, ack, err
  );

  modport slave (
    output req, req_len, req_port, done,
    input  start, len, dst_port, grant, ack, err
  );
endinterface

// File: rtl/udp_tx_sched.sv
// Round-robin owner of the single UDP transmit engine: grant, one-cycle start, wait for done
// (or watchdog timeout), then a holdoff gap before the next grant.
module udp_tx_sched #(
  parameter int N       = 4,
  parameter int TIMEOUT = 50000,
  parameter int HOLDOFF = 8
) (
  input  logic           clk_100,
  input  logic           rst,
  udp_tx_sched_if.master bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [23:0]   WD_LIMIT = 24'(TIMEOUT - 1);
  localparam logic [23:0]   WD_MAX   = 24'hFF_FFFF;
  localparam logic [7:0]    GAP_LAST = 8'(HOLDOFF);
  localparam logic [IW-1:0] PTR_INIT = IW'(N - 1);

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] pick;
  logic          found;
  logic [23:0]   wd;
  logic [7:0]    hold;
  logic          done_hit;
  logic          wd_hit;
  logic          finish;
  logic          grab;

  logic          start_q;
  logic          err_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  ack_q;
  logic [10:0]   len_q;
  logic [15:0]   port_q;

  // First requester strictly after the last served one, wrapping modulo N.
  always_comb begin
    int cand;
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  assign grab     = (state == S_IDLE) && found;
  assign done_hit = (state == S_WAIT) && bus.done;
  assign wd_hit   = (state == S_WAIT) && (wd == WD_LIMIT);
  assign finish   = done_hit || wd_hit;

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (found) state <= S_START;
        S_START: state <= S_WAIT;
        S_WAIT:  if (finish) state <= S_GAP;
        S_GAP:   if (hold == GAP_LAST) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The descriptor only moves at a grant; the engine keeps re-sampling it until the next one.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      len_q   <= '0;
      port_q  <= '0;
      grant_q <= '0;
    end else if (grab) begin
      idx     <= pick;
      len_q   <= bus.req_len[int'(pick)*11 +: 11];
      port_q  <= bus.req_port[int'(pick)*16 +: 16];
      grant_q <= N'(1) << pick;
    end else if (finish) begin
      grant_q <= '0;
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      ptr <= PTR_INIT;
    end else if (finish) begin
      ptr <= idx;
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (state == S_START) begin
      wd <= '0;
    end else if (state == S_WAIT && !finish && wd != WD_MAX) begin
      wd <= wd + 24'd1;
    end
  end

  // The gap spans the ack cycle plus HOLDOFF counted cycles.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (finish) begin
      hold <= '0;
    end else if (state == S_GAP && hold != GAP_LAST) begin
      hold <= hold + 8'd1;
    end
  end

  // A done arriving on the watchdog's last cycle counts as a normal completion.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= grab;
      ack_q   <= finish ? (N'(1) << idx) : '0;
      err_q   <= finish && !bus.done;
    end
  end

  assign bus.start    = start_q;
  assign bus.len      = len_q;
  assign bus.dst_port = port_q;
  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Scoreboard bench for udp_tx_sched: stimulus predicts each start and ack from the round-robin
// rules, a separate monitor pops and compares whenever the scheduler emits start or ack/err.
module tb_udp_tx_sched;

  localparam int N       = 4;
  localparam int TIMEOUT = 100;
  localparam int HOLDOFF = 8;

  typedef struct {
    int          src;
    logic [10:0] len;
    logic [15:0] port;
    bit          gap_exact;
  } start_exp_t;

  typedef struct {
    int src;
    bit err;
    int lat;
  } ack_exp_t;

  logic clk_100 = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;

  start_exp_t exp_starts[$];
  ack_exp_t   exp_acks[$];

  int n_checks  = 0;
  int n_pass    = 0;
  int model_ptr = N - 1;
  bit after_ack = 1'b0;

  udp_tx_sched_if #(.N(N)) bus ();

  udp_tx_sched #(
    .N(N),
    .TIMEOUT(TIMEOUT),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk_100(clk_100),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Served order: sources listed starting just after the last owner, first requesting one wins.
  function automatic int pickWinner(input logic [N-1:0] rv, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[i]) if (rv[order[i]]) return order[i];
    return -1;
  endfunction

  // One frame: d in 1..TIMEOUT pulses done d cycles after start; d=0 never pulses done;
  // d > TIMEOUT lets the watchdog fire and then pulses a stray done into the gap.
  task automatic applyStimulus(input logic [N-1:0] rv, input int d, input bit drop, input bit rand_desc);
    int w;
    bit got;
    bit got_ack;
    if (rand_desc) begin
      for (int i = 0; i < N; i++) begin
        bus.req_len[i*11 +: 11]  = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
        bus.req_port[i*16 +: 16] = 16'($urandom);
      end
    end
    bus.req = rv;
    w = pickWinner(rv, model_ptr);
    exp_starts.push_back('{src: w, len: bus.req_len[w*11 +: 11], port: bus.req_port[w*16 +: 16],
                           gap_exact: after_ack});
    after_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2*HOLDOFF + 20 && !got; i++) begin
      @(negedge clk_100);
      got = bus.start;
    end
    if (!got) begin
      checkOutput("start_seen", 0, 1);
      return;
    end
    if (d >= 1 && d <= TIMEOUT) exp_acks.push_back('{src: w, err: 1'b0, lat: d + 1});
    else                        exp_acks.push_back('{src: w, err: 1'b1, lat: TIMEOUT + 1});
    model_ptr = w;
    got_ack = 1'b0;
    for (int cnt = 1; cnt <= TIMEOUT + HOLDOFF + 10; cnt++) begin
      @(negedge clk_100);
      bus.done = (cnt == d);
      if (drop && cnt == 1) bus.req[w] = 1'b0;
      if (bus.ack != '0) got_ack = 1'b1;
      if (got_ack && (d <= TIMEOUT || cnt > d)) break;
    end
    bus.done = 1'b0;
    if (!got_ack) checkOutput("ack_seen", 0, 1);
    after_ack = got_ack && (d <= TIMEOUT);
  endtask

  // Monitor: compares every start and every ack/err against the head of its queue.
  initial begin
    logic [10:0] cur_len;
    logic [15:0] cur_port;
    bit          moved;
    bit          have_ack;
    int          last_ack_cyc;
    int          last_start_cyc;
    start_exp_t  se;
    ack_exp_t    ae;
    cur_len = '0; cur_port = '0; moved = 1'b0; have_ack = 1'b0;
    last_ack_cyc = 0; last_start_cyc = 0;
    forever begin
      @(negedge clk_100);
      if (rst) begin
        cur_len  = '0;
        cur_port = '0;
        moved    = 1'b0;
        have_ack = 1'b0;
      end else begin
        if (bus.start) begin
          if (exp_starts.size() == 0) begin
            checkOutput("unexpected_start", 1, 0);
          end else begin
            se = exp_starts.pop_front();
            checkOutput("grant", bus.grant, 1 << se.src);
            checkOutput("len", bus.len, se.len);
            checkOutput("dst_port", bus.dst_port, se.port);
            if (have_ack) checkOutput("start_gap_min", (cyc - last_ack_cyc) >= HOLDOFF + 2, 1);
            if (se.gap_exact) checkOutput("start_gap", cyc - last_ack_cyc, HOLDOFF + 2);
            cur_len  = se.len;
            cur_port = se.port;
          end
          moved = 1'b0;
          last_start_cyc = cyc;
        end else if (bus.len != cur_len || bus.dst_port != cur_port) begin
          moved = 1'b1;
        end
        if (bus.ack != '0 || bus.err) begin
          if (exp_acks.size() == 0) begin
            checkOutput("unexpected_ack", {bus.err, bus.ack}, 0);
          end else begin
            ae = exp_acks.pop_front();
            checkOutput("ack", bus.ack, 1 << ae.src);
            checkOutput("err", bus.err, ae.err);
            checkOutput("ack_latency", cyc - last_start_cyc, ae.lat);
            checkOutput("grant_released", bus.grant, 0);
            checkOutput("desc_held", moved, 0);
          end
          last_ack_cyc = cyc;
          have_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    bus.req      = '0;
    bus.req_len  = '0;
    bus.req_port = '0;
    bus.done     = 1'b0;
    repeat (3) @(negedge clk_100);
    rst = 1'b0;
    @(negedge clk_100);
    checkOutput("rst_start", bus.start, 0);
    checkOutput("rst_grant", bus.grant, 0);
    checkOutput("rst_ack", bus.ack, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_len", bus.len, 0);
    checkOutput("rst_dst_port", bus.dst_port, 0);

    $display("[TB] fairness with all sources requesting");
    for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 10, 1'b0, 1'b1);

    $display("[TB] single requester with fixed descriptor");
    bus.req_len[10:0]  = 11'd64;
    bus.req_port[15:0] = 16'd11300;
    applyStimulus(4'b0001, 60, 1'b0, 1'b0);

    $display("[TB] zero-length frame");
    bus.req_len[2*11 +: 11] = 11'd0;
    applyStimulus(4'b0100, 7, 1'b0, 1'b0);

    $display("[TB] watchdog timeout then next owner");
    applyStimulus(4'b0100, 0, 1'b0, 1'b1);
    applyStimulus(4'b1101, 5, 1'b0, 1'b1);

    $display("[TB] done on the watchdog limit, stray done in gap");
    applyStimulus(4'b0011, TIMEOUT, 1'b0, 1'b1);
    applyStimulus(4'b1000, TIMEOUT + 3, 1'b0, 1'b1);

    $display("[TB] requester drops after grant");
    applyStimulus(4'b0010, 20, 1'b1, 1'b1);

    $display("[TB] done pulses while idle");
    bus.req = '0;
    repeat (HOLDOFF + 6) @(negedge clk_100);
    for (int i = 0; i < 3; i++) begin
      bus.done = 1'b1;
      @(negedge clk_100);
      bus.done = 1'b0;
      repeat (2) @(negedge clk_100);
    end
    after_ack = 1'b0;
    applyStimulus(4'b0101, 12, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-frame");
    bus.req = 4'b0011;
    exp_starts.push_back('{src: pickWinner(4'b0011, model_ptr), len: bus.req_len[pickWinner(4'b0011, model_ptr)*11 +: 11],
                           port: bus.req_port[pickWinner(4'b0011, model_ptr)*16 +: 16], gap_exact: after_ack});
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 2*HOLDOFF + 20 && !got; i++) begin
        @(negedge clk_100);
        got = bus.start;
      end
      if (!got) checkOutput("start_seen_rst", 0, 1);
    end
    repeat (5) @(negedge clk_100);
    #2;
    rst = 1'b1;
    bus.req = '0;
    #1;
    checkOutput("arst_start", bus.start, 0);
    checkOutput("arst_grant", bus.grant, 0);
    checkOutput("arst_ack", bus.ack, 0);
    checkOutput("arst_err", bus.err, 0);
    checkOutput("arst_len", bus.len, 0);
    checkOutput("arst_dst_port", bus.dst_port, 0);
    repeat (3) @(negedge clk_100);
    rst = 1'b0;
    model_ptr = N - 1;
    after_ack = 1'b0;
    applyStimulus(4'b1111, 15, 1'b0, 1'b1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 25; i++) begin
      int mode;
      int d;
      mode = $urandom_range(0, 9);
      if (mode <= 5)      d = $urandom_range(1, TIMEOUT - 1);
      else if (mode == 6) d = TIMEOUT;
      else if (mode == 7) d = 0;
      else                d = TIMEOUT + 1 + $urandom_range(0, HOLDOFF);
      applyStimulus(N'($urandom_range(1, (1 << N) - 1)), d, 1'b0, 1'b1);
    end

    bus.req = '0;
    repeat (HOLDOFF + 10) @(negedge clk_100);
    checkOutput("starts_drained", exp_starts.size(), 0);
    checkOutput("acks_drained", exp_acks.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
